tt_characterizer: RTL and testbench



---
 rtl/tt_characterizer_if.sv | 35 +++
 rtl/tt_characterizer.sv | 167 ++++++++++++++++
 tb/tb_tt_characterizer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_characterizer_if.sv
// tt_characterizer_if: bus between the truth-table characterizer and its harness.
// The slave modport is the characterizer itself; the master modport is the
// harness side that requests sweeps and returns the gate-under-test response.
interface tt_characterizer_if;
  logic       start;
  logic [2:0] stim;
  logic       resp;
  logic       busy;
  logic       done;
  logic [7:0] tt_id;
  logic       match;
  logic       unstable;

  modport master (
    output start,
    output resp,
    input  stim,
    input  busy,
    input  done,
    input  tt_id,
    input  match,
    input  unstable
  );

  modport slave (
    input  start,
    input  resp,
    output stim,
    output busy,
    output done,
    output tt_id,
    output match,
    output unstable
  );
endinterface

// File: rtl/tt_characterizer.sv
// tt_characterizer: sweeps all 8 input rows of a 3-input gate, holds each row
// for SETTLE cycles, samples the response on the last cycle of the row and
// assembles the truth-table ID (row r lands in tt_id[7-r]). The assembled ID
// is compared against EXP_ID to produce the match flag.
//
// Optional feature macro: TT_GLITCH_CHECK_EN
//   When defined, the response is also captured one cycle before the final
//   sample of every row; a difference between the two raises a sticky
//   'unstable' flag, which also forces match low. When undefined, unstable
//   is tied low and only the single final sample is taken.
module tt_characterizer #(
  parameter logic [7:0] EXP_ID = 8'h3B,
  parameter int         SETTLE = 4      // legal range 1..255
) (
  input  logic              clk,
  input  logic              rst_n,
  tt_characterizer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Settle count at which the row is sampled.
  localparam logic [7:0] LAST_SETTLE = 8'(SETTLE - 1);

  state_t     state_reg, state_next;
  logic [2:0] row_reg, row_next;
  logic [7:0] settle_reg, settle_next;
  logic [2:0] stim_reg, stim_next;
  logic [7:0] tt_reg, tt_next;
  logic       match_reg, match_next;

  // Row position of the sampled bit: row 000 is the MSB of the ID.
  logic [2:0] tt_bit;
  assign tt_bit = 3'd7 - row_reg;

  // A row is sampled on the edge that ends its final settle cycle.
  logic sample_now;
  assign sample_now = (state_reg == DRIVE) && (settle_reg == LAST_SETTLE);

`ifdef TT_GLITCH_CHECK_EN
  // With SETTLE=1 there is only one sample per row, so nothing to compare.
  localparam bit         HAS_PAIR    = (SETTLE >= 2);
  localparam logic [7:0] PREV_SETTLE = HAS_PAIR ? 8'(SETTLE - 2) : 8'd0;

  logic unstable_reg, unstable_next;
  logic prev_reg, prev_next;
  logic glitch;

  // Penultimate-cycle response disagreeing with the final sample means the
  // gate output was still moving inside the settle window.
  assign glitch = HAS_PAIR && sample_now && (bus.resp != prev_reg);
`endif

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      row_reg      <= 3'd0;
      settle_reg   <= 8'd0;
      stim_reg     <= 3'b000;
      tt_reg       <= 8'h00;
      match_reg    <= 1'b0;
`ifdef TT_GLITCH_CHECK_EN
      unstable_reg <= 1'b0;
      prev_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      row_reg      <= row_next;
      settle_reg   <= settle_next;
      stim_reg     <= stim_next;
      tt_reg       <= tt_next;
      match_reg    <= match_next;
`ifdef TT_GLITCH_CHECK_EN
      unstable_reg <= unstable_next;
      prev_reg     <= prev_next;
`endif
    end
  end

  // Next-state and datapath update: sweep rows, sample, assemble, compare.
  always_comb begin
    state_next    = state_reg;
    row_next      = row_reg;
    settle_next   = settle_reg;
    stim_next     = stim_reg;
    tt_next       = tt_reg;
    match_next    = match_reg;
`ifdef TT_GLITCH_CHECK_EN
    unstable_next = unstable_reg;
    prev_next     = prev_reg;
`endif

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next    = DRIVE;
          row_next      = 3'd0;
          settle_next   = 8'd0;
          stim_next     = 3'b000;
          // Results of the previous sweep are dropped only when a new one begins.
          tt_next       = 8'h00;
          match_next    = 1'b0;
`ifdef TT_GLITCH_CHECK_EN
          unstable_next = 1'b0;
`endif
        end
      end

      DRIVE: begin
`ifdef TT_GLITCH_CHECK_EN
        if (HAS_PAIR && (settle_reg == PREV_SETTLE)) begin
          prev_next = bus.resp;
        end
        if (glitch) begin
          unstable_next = 1'b1;
        end
`endif
        if (sample_now) begin
          tt_next[tt_bit] = bus.resp;
          settle_next     = 8'd0;
          if (row_reg == 3'd7) begin
            // Match is registered alongside the final sample so it is valid
            // in the DONE cycle.
            state_next = DONE;
            stim_next  = 3'b000;
`ifdef TT_GLITCH_CHECK_EN
            match_next = (tt_next == EXP_ID) && !unstable_next;
`else
            match_next = (tt_next == EXP_ID);
`endif
          end else begin
            row_next  = row_reg + 3'd1;
            stim_next = row_reg + 3'd1;
          end
        end else begin
          settle_next = settle_reg + 8'd1;
        end
      end

      DONE: begin
        // Single-cycle completion; a start seen here is deliberately ignored.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.stim  = stim_reg;
  assign bus.busy  = (state_reg == DRIVE);
  assign bus.done  = (state_reg == DONE);
  assign bus.tt_id = tt_reg;
  assign bus.match = match_reg;
`ifdef TT_GLITCH_CHECK_EN
  assign bus.unstable = unstable_reg;
`else
  assign bus.unstable = 1'b0;
`endif

endmodule

// File: tb/tb_tt_characterizer.sv
// tb_tt_characterizer: two characterizers (SETTLE=4 and SETTLE=1) driven by a
// cycle-accurate gate model. Table of sweeps with expected IDs, randomized
// gate functions and settle-window noise, plus hand-written reset and
// start-during-sweep sequences. Honours TT_GLITCH_CHECK_EN if defined.
module tb_tt_characterizer;

  localparam int SA = 4;
  localparam int SB = 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  tt_characterizer_if ifa ();
  tt_characterizer_if ifb ();

  tt_characterizer #(.EXP_ID(8'h3B), .SETTLE(SA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  tt_characterizer #(.EXP_ID(8'h3B), .SETTLE(SB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] stim;
    logic       busy;
    logic       done;
    logic [7:0] tt;
    logic       match;
    logic       unst;
  } obs_t;

  typedef struct {
    int         sel;        // 0 = SETTLE 4 unit, 1 = SETTLE 1 unit
    logic [7:0] lut;        // lut[r] = gate output for row r = {in1,in2,in3}
    bit         noise;      // random resp in early settle cycles
    int         mid_k;      // edge at which a stray start is pulsed (-1 none)
    int         glitch_row; // row disturbed in its penultimate cycle (-1 none)
    bit         done_start; // pulse start during the DONE cycle
    logic [7:0] exp_tt;
    logic       exp_match;
    logic       exp_unst;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) ifa.start = v;
    else          ifb.start = v;
  endtask

  task automatic set_resp(input int sel, input logic v);
    if (sel == 0) ifa.resp = v;
    else          ifb.resp = v;
  endtask

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.stim = ifa.stim; o.busy = ifa.busy; o.done = ifa.done;
      o.tt = ifa.tt_id;  o.match = ifa.match; o.unst = ifa.unstable;
    end else begin
      o.stim = ifb.stim; o.busy = ifb.busy; o.done = ifb.done;
      o.tt = ifb.tt_id;  o.match = ifb.match; o.unst = ifb.unstable;
    end
    return o;
  endfunction

  function automatic int settle_of(input int sel);
    return (sel == 0) ? SA : SB;
  endfunction

  // Gate models written as Boolean expressions of in1, in2, in3.
  function automatic logic [7:0] lut_of(input int kind);
    logic [7:0] l;
    for (int r = 0; r < 8; r++) begin
      logic in1, in2, in3;
      in1 = (r >= 4);
      in2 = ((r % 4) >= 2);
      in3 = ((r % 2) == 1);
      case (kind)
        0:       l[r] = in2 | (in1 & ~in3);  // the 0x3B gate
        1:       l[r] = 1'b0;
        2:       l[r] = 1'b1;
        default: l[r] = ~in3;                // inverter on in3
      endcase
    end
    return l;
  endfunction

  // Reference ID: row 0 first, shifted in MSB-first.
  function automatic logic [7:0] ref_id(input logic [7:0] lut);
    int id = 0;
    for (int r = 0; r < 8; r++) id = id * 2 + int'(lut[r]);
    return 8'(id);
  endfunction

  function automatic vec_t mk(input int sel, input logic [7:0] lut, input bit noise,
                              input int mid_k, input int grow, input bit dstart,
                              input logic [7:0] ett, input logic em, input logic eu);
    vec_t v;
    v.sel = sel; v.lut = lut; v.noise = noise; v.mid_k = mid_k;
    v.glitch_row = grow; v.done_start = dstart;
    v.exp_tt = ett; v.exp_match = em; v.exp_unst = eu;
    return v;
  endfunction

  // One complete sweep; entered and left at #1 after a rising edge with the unit idle.
  task automatic run_sweep(input vec_t v);
    int   s_len;
    int   stim_err;
    int   busy_err;
    obs_t o;
    obs_t o_done;
    s_len    = settle_of(v.sel);
    stim_err = 0;
    busy_err = 0;

    set_start(v.sel, 1'b1);
    set_resp(v.sel, 1'b0);
    @(posedge clk); #1;
    set_start(v.sel, 1'b0);

    for (int k = 1; k <= 8 * s_len; k++) begin
      int   row;
      int   s;
      logic rv;
      row = (k - 1) / s_len;
      s   = (k - 1) % s_len;
      o   = get_obs(v.sel);
      if (k == 1) chk("tt_clear_on_start", {o.tt, 2'b00, o.match, o.unst}, 32'h0);
      if (o.stim != 3'(row)) stim_err++;
      if (!o.busy || o.done) busy_err++;
      rv = v.lut[row];
      if (s_len >= 2 && s == s_len - 2 && row == v.glitch_row) rv = ~rv;
      else if (v.noise && s < s_len - 2) rv = 1'($urandom_range(0, 1));
      set_resp(v.sel, rv);
      set_start(v.sel, k == v.mid_k);
      @(posedge clk); #1;
    end
    set_start(v.sel, 1'b0);

    chk("stim_sequence", stim_err, 0);
    chk("busy_during_sweep", busy_err, 0);

    o_done = get_obs(v.sel);
    chk("done_pulse", {o_done.done, o_done.busy, o_done.stim}, {27'd0, 1'b1, 1'b0, 3'b000});
    chk("tt_id", o_done.tt, v.exp_tt);
    chk("match", o_done.match, v.exp_match);
    chk("unstable", o_done.unst, v.exp_unst);
    $display("sweep dut=%0d settle=%0d lut=%02h tt_id=%02h exp=%02h match=%0b unstable=%0b",
             v.sel, s_len, v.lut, o_done.tt, v.exp_tt, o_done.match, o_done.unst);

    // Optionally request a new sweep during DONE; it must be ignored.
    set_start(v.sel, v.done_start);
    @(posedge clk); #1;
    set_start(v.sel, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    o = get_obs(v.sel);
    chk("hold_after_done", {o.busy, o.done, o.tt, o.match, o.unst},
        {1'b0, 1'b0, o_done.tt, o_done.match, o_done.unst});
  endtask

  vec_t vt[15];

  initial begin
    obs_t o;
    int   n_done;
    logic gl_u;

`ifdef TT_GLITCH_CHECK_EN
    gl_u = 1'b1;
`else
    gl_u = 1'b0;
`endif

    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.resp = 1'b0;
    ifb.start = 1'b0; ifb.resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      o = get_obs(u);
      chk("reset_state", {o.stim, o.busy, o.done, o.tt, o.match, o.unst}, 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    vt[0] = mk(0, lut_of(0), 0, -1, -1, 1, 8'h3B, 1'b1, 1'b0);
    vt[1] = mk(0, lut_of(1), 0, -1, -1, 0, 8'h00, 1'b0, 1'b0);
    vt[2] = mk(0, lut_of(2), 0, -1, -1, 0, 8'hFF, 1'b0, 1'b0);
    vt[3] = mk(0, lut_of(0), 0, 10, -1, 0, 8'h3B, 1'b1, 1'b0);
    vt[4] = mk(1, lut_of(3), 0, -1, -1, 1, 8'hAA, 1'b0, 1'b0);
    vt[5] = mk(1, lut_of(0), 0, 3,  -1, 0, 8'h3B, 1'b1, 1'b0);
    vt[6] = mk(0, lut_of(0), 0, -1, 5,  0, 8'h3B, !gl_u, gl_u);
    vt[7] = mk(0, lut_of(0), 0, -1, -1, 0, 8'h3B, 1'b1, 1'b0);
    vt[8] = mk(1, lut_of(0), 0, -1, 5,  0, 8'h3B, 1'b1, 1'b0);
    for (int i = 9; i < 15; i++) begin
      logic [7:0] l;
      int         sel;
      l   = (i == 9) ? lut_of(0) : 8'($urandom_range(0, 255));
      sel = int'($urandom_range(0, 1));
      vt[i] = mk(sel, l, 1, -1, -1, bit'($urandom_range(0, 1)),
                 ref_id(l), ref_id(l) == 8'h3B, 1'b0);
    end

    for (int i = 0; i < 15; i++) run_sweep(vt[i]);

    // Reset in the middle of a sweep: partial ID dropped, no done follows.
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      ifa.resp = lut_of(0)[(k - 1) / SA];
      @(posedge clk); #1;
    end
    chk("partial_tt_before_reset", ifa.tt_id, 8'h20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    o = get_obs(0);
    chk("mid_sweep_reset", {o.stim, o.busy, o.done, o.tt, o.match, o.unst}, 32'h0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (ifa.done || ifa.busy) n_done++;
      @(posedge clk); #1;
    end
    chk("no_activity_after_reset", n_done, 0);

    run_sweep(mk(0, lut_of(0), 0, -1, -1, 0, 8'h3B, 1'b1, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
